mem_dma_master: RTL and testbench

// - Bus initiator for the Cobra1 64 KiB memory port: block-copies LEN bytes from SRC to DST.
// - Drives mreq/rd/wr/addr/data exactly as the CPU would; sits beside the Z80 core.
// - Obtains the bus through a bus_req/bus_ack handshake with the CPU.
// - Enforces the ROM write-protect window itself rather than relying on memory to drop writes.

---
 rtl/cobra_bus_pkg.sv | 31 +++
 rtl/mem_dma_master.sv | 160 ++++++++++++++++
 tb/tb_mem_dma_master.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cobra_bus_pkg.sv
// Shared definitions for Cobra1 memory-port bus initiators.
//   ROM_BASE_DEF / ROM_SIZE_DEF : default write-protected ROM window [base, base+size)
//   dma_state_t                 : DMA master FSM states (3-bit encoding)
//   in_rom_window()             : true when an address falls inside the ROM window
package cobra_bus_pkg;

  localparam logic [15:0] ROM_BASE_DEF = 16'hC000;
  localparam logic [15:0] ROM_SIZE_DEF = 16'h0800;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } dma_state_t;

  // Compared in 17 bits so a window ending exactly at 64 KiB does not wrap.
  function automatic logic in_rom_window(input logic [15:0] addr,
                                         input logic [15:0] base = ROM_BASE_DEF,
                                         input logic [15:0] size = ROM_SIZE_DEF);
    logic [16:0] a;
    logic [16:0] lo;
    logic [16:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/mem_dma_master.sv
// Block-copy bus initiator for the Cobra1 64 KiB memory port.
// Requests the bus from the CPU, then copies len bytes from src to dst in
// ascending order at two cycles per byte (one read cycle, one write cycle).
// Writes landing in the ROM window are suppressed here and flagged on rom_skip.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start, src, dst, len  transfer request and its parameters (latched in IDLE)
//   abort                 finish the current byte, then stop
//   busy, done, rom_skip  status: busy span, 1-cycle done pulse, sticky ROM-skip flag
//   bus_req, bus_ack      bus ownership handshake with the CPU
//   mem_*                 CPU-style memory port (registered strobes)
module mem_dma_master
  import cobra_bus_pkg::*;
#(
  parameter logic [15:0] ROM_BASE = ROM_BASE_DEF,
  parameter logic [15:0] ROM_SIZE = ROM_SIZE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic [15:0] len,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        rom_skip,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_mreq,
  output logic        mem_rd,
  output logic        mem_wr
);

  dma_state_t  state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  buf_q, buf_d;
  logic        rom_skip_q, rom_skip_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bus_req_q, bus_req_d;
  logic        mreq_q, mreq_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      rom_skip_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      mreq_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      rom_skip_q <= rom_skip_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bus_req_q  <= bus_req_d;
      mreq_q     <= mreq_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    rom_skip_d = rom_skip_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d      = src;
          dst_d      = dst;
          cnt_d      = len;
          rom_skip_d = 1'b0;
          state_d    = (len == 16'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (abort)        state_d = S_DONE;
        else if (bus_ack) state_d = S_RD;
      end
      S_RD: begin
        buf_d   = mem_rdata;
        state_d = S_WR;
      end
      S_WR: begin
        if (in_rom_window(dst_q, ROM_BASE, ROM_SIZE)) rom_skip_d = 1'b1;
        src_d   = src_q + 16'd1;
        dst_d   = dst_q + 16'd1;
        cnt_d   = cnt_q - 16'd1;
        state_d = ((cnt_d == 16'd0) || abort) ? S_DONE : S_RD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: decode them from the state being entered so the
    // strobes line up with the state they belong to.
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    bus_req_d = (state_d == S_REQ) || (state_d == S_RD) || (state_d == S_WR);
    mreq_d    = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;
    if (state_d == S_RD) begin
      mreq_d = 1'b1;
      rd_d   = 1'b1;
      addr_d = src_d;
    end else if (state_d == S_WR) begin
      addr_d  = dst_d;
      wdata_d = buf_d;
      // Protected bytes still take their write slot, just without strobes.
      if (!in_rom_window(dst_d, ROM_BASE, ROM_SIZE)) begin
        mreq_d = 1'b1;
        wr_d   = 1'b1;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_skip  = rom_skip_q;
  assign bus_req   = bus_req_q;
  assign mem_mreq  = mreq_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_dma_master.sv
// Self-checking bench for mem_dma_master: a 64 KiB memory model answers the
// DUT's bus cycles, and a byte-array reference applies each copy directly
// from the transfer rules (ascending copy, ROM-window bytes left alone).
module tb_mem_dma_master;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] src_i, dst_i, len_i;
  logic        abort;
  logic        busy, done, rom_skip, bus_req, bus_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_mreq, mem_rd, mem_wr;

  bit   [7:0]  mem     [0:65535];
  bit   [7:0]  ref_mem [0:65535];
  logic        poke_en;
  logic [15:0] poke_a;
  logic [7:0]  poke_d;
  int          wr_cnt = 0;

  int n_chk = 0;
  int n_err = 0;

  mem_dma_master dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src      (src_i),
    .dst      (dst_i),
    .len      (len_i),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .rom_skip (rom_skip),
    .bus_req  (bus_req),
    .bus_ack  (bus_ack),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_mreq (mem_mreq),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (mem_mreq && mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_mreq && mem_wr) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit rom_hit(input int a);
    return (a >= 'hC000) && (a < 'hC800);
  endfunction

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Reference copy: byte by byte, ascending, so overlap behaves like the hardware.
  task automatic ref_copy(input logic [15:0] s, input logic [15:0] d, input int n,
                          output bit skipped, output int writes);
    int as, ad;
    skipped = 0;
    writes  = 0;
    for (int i = 0; i < n; i++) begin
      as = (int'(s) + i) % 65536;
      ad = (int'(d) + i) % 65536;
      if (rom_hit(ad)) skipped = 1;
      else begin
        ref_mem[ad] = ref_mem[as];
        writes++;
      end
    end
  endtask

  task automatic cmp_mem(input string tag);
    int bad = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] != ref_mem[a]) bad++;
    chk({tag, ":mem"}, bad, 0);
  endtask

  // One transfer: dly = REQ cycles with bus_ack low, spur = extra start while
  // busy, abort_at = abort during the write of that byte number (0 = none).
  task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input int dly, input bit spur, input int abort_at, input string tag);
    int edges, wseen, viol, n_exp, w0, exp_writes, exp_edges;
    bit exp_skip, got_done;
    src_i = s; dst_i = d; len_i = l;
    bus_ack = (dly == 0);
    w0 = wr_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ":busy_after_start"}, busy, 1);
    if (l == 0) chk({tag, ":no_bus_req"}, bus_req, 0);
    edges = 0; wseen = 0; viol = 0;
    got_done = done;
    while (!got_done && edges < 2000) begin
      if (edges == dly) bus_ack = 1'b1;
      if (spur && edges == 3) begin
        start = 1'b1; src_i = 16'h4000; dst_i = 16'h5000; len_i = 16'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      edges++;
      if (mem_rd && mem_wr) viol++;
      if (!bus_req && (mem_mreq || mem_rd || mem_wr)) viol++;
      if (!bus_ack && (mem_mreq || mem_rd || mem_wr || mem_addr != 0 || mem_wdata != 0)) viol++;
      if (!bus_ack && !bus_req) viol++;
      if (!busy) viol++;
      if (mem_wr) wseen++;
      if (abort_at != 0 && mem_wr && wseen == abort_at) abort = 1'b1;
      got_done = done;
    end
    n_exp     = (abort_at != 0) ? abort_at : int'(l);
    exp_edges = (l == 0) ? 0 : 1 + dly + 2 * n_exp;
    chk({tag, ":done"}, done, 1);
    chk({tag, ":latency"}, edges, exp_edges);
    chk({tag, ":done_bus_idle"}, {bus_req, mem_mreq, mem_rd, mem_wr}, 0);
    @(posedge clk); #1;
    chk({tag, ":after_done"}, {busy, done}, 0);
    if (spur) begin
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (busy || done || bus_req) viol++;
      end
    end
    chk({tag, ":protocol"}, viol, 0);
    ref_copy(s, d, n_exp, exp_skip, exp_writes);
    chk({tag, ":rom_skip"}, rom_skip, exp_skip);
    chk({tag, ":writes"}, wr_cnt - w0, exp_writes);
    cmp_mem(tag);
    bus_ack = 1'b0;
  endtask

  initial begin
    int w0, edges, ex_writes;
    bit ex_skip;
    logic [15:0] rs, rd_, rl;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; bus_ack = 1'b0;
    src_i = '0; dst_i = '0; len_i = '0;
    poke_en = 1'b0; poke_a = '0; poke_d = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_status", {busy, done, rom_skip, bus_req}, 0);
    chk("reset_strobes", {mem_mreq, mem_rd, mem_wr}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic 16-byte copy with bus already granted
    for (int i = 0; i < 16; i++) poke(16'h1000 + 16'(i), 8'(i));
    run_xfer(16'h1000, 16'h2000, 16'd16, 0, 0, 0, "copy16");
    chk("copy16_last_byte", mem[16'h200F], 8'h0F);

    // Grant delayed 10 cycles
    run_xfer(16'h1000, 16'h2100, 16'd4, 10, 0, 0, "ack_wait");

    // Destination crossing the end of the ROM window
    for (int i = 0; i < 4; i++) poke(16'h1100 + 16'(i), 8'hA0 + 8'(i));
    run_xfer(16'h1100, 16'hC7FE, 16'd4, 0, 0, 0, "rom_edge");
    chk("rom_edge_C800", mem[16'hC800], 8'hA2);

    // Reset clears the sticky flag
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_clears_rom_skip", rom_skip, 0);
    reset_n = 1'b1;

    // Source wrapping through 0xFFFF
    poke(16'hFFFE, 8'hAA); poke(16'hFFFF, 8'hBB); poke(16'h0000, 8'hCC); poke(16'h0001, 8'hDD);
    run_xfer(16'hFFFE, 16'h3000, 16'd4, 0, 0, 0, "src_wrap");
    chk("src_wrap_3002", mem[16'h3002], 8'hCC);

    // Zero-length request and start while busy
    run_xfer(16'h1000, 16'h2400, 16'd0, 0, 0, 0, "len0");
    run_xfer(16'h1000, 16'h2200, 16'd8, 0, 1, 0, "spur_start");

    // Abort during the third byte of a long copy
    for (int i = 0; i < 8; i++) poke(16'h8000 + 16'(i), 8'h50 + 8'(i));
    run_xfer(16'h8000, 16'h9000, 16'd100, 0, 0, 3, "abort");

    // Reset in the middle of a write cycle
    for (int i = 0; i < 4; i++) poke(16'h6000 + 16'(i), 8'h70 + 8'(i));
    src_i = 16'h6000; dst_i = 16'h7000; len_i = 16'd4; bus_ack = 1'b1;
    w0 = wr_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    while (!mem_wr && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("rst_mid:reached_wr", mem_wr, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid:strobes", {mem_mreq, mem_rd, mem_wr, bus_req}, 0);
    chk("rst_mid:busy", busy, 0);
    chk("rst_mid:addr", mem_addr, 0);
    reset_n = 1'b1;
    bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid:stays_idle", {busy, done, bus_req}, 0);
    ref_copy(16'h6000, 16'h7000, 1, ex_skip, ex_writes);
    chk("rst_mid:writes", wr_cnt - w0, ex_writes);
    cmp_mem("rst_mid");

    // Randomized transfers, biased toward the ROM window edges
    for (int it = 0; it < 24; it++) begin
      rs  = 16'($urandom);
      rd_ = 16'($urandom);
      rl  = 16'($urandom_range(1, 24));
      if (it % 4 == 0) rd_ = 16'hC7F0 + 16'($urandom_range(0, 31));
      if (it % 4 == 1) rd_ = 16'hBFF0 + 16'($urandom_range(0, 31));
      if (it % 4 == 2) rd_ = rs + 16'($urandom_range(1, 4));
      for (int i = 0; i < int'(rl); i++) poke(rs + 16'(i), 8'($urandom));
      run_xfer(rs, rd_, rl, int'($urandom_range(0, 4)), 0, 0, $sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
